// File: rtl/laser_cover_search.sv
// Two-circle laser coverage search: loads a frame of points, then runs alternating
// exhaustive grid sweeps for C1 and C2 until the best cover count stops improving.
module laser_cover_search #(
    parameter int W        = 4,
    parameter int N_PTS    = 40,
    parameter int R2       = 16,
    parameter int MAX_ITER = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [W-1:0]                 X,
    input  logic [W-1:0]                 Y,
    output logic [W-1:0]                 C1X,
    output logic [W-1:0]                 C1Y,
    output logic [W-1:0]                 C2X,
    output logic [W-1:0]                 C2Y,
    output logic [$clog2(N_PTS+1)-1:0]   COVER,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [2:0]                   DBG_STATE
);

    localparam int CW = $clog2(N_PTS + 1);
    localparam int IW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam int TW = $clog2(MAX_ITER + 1);
    localparam logic [W-1:0]  CTR      = W'((1 << (W - 1)) - 1);
    localparam logic [W-1:0]  MAXC     = '1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PTS - 1);
    localparam logic [TW-1:0] ITER_LIM = TW'(MAX_ITER);
    localparam logic [31:0]   R2_U     = 32'(R2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SWEEP1 = 3'd2,
        S_SWEEP2 = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_px [N_PTS];
    logic [W-1:0]   r_py [N_PTS];
    logic [IW-1:0]  r_idx;
    logic           r_cmp;
    logic [W-1:0]   r_cx, r_cy;
    logic [W-1:0]   r_c1x, r_c1y, r_c2x, r_c2y;
    logic [CW-1:0]  r_count, r_best, r_best_iter, r_cover;
    logic [TW-1:0]  r_iter;
    logic           r_ready, r_busy, r_done;

    // Squared distance kept at 2W+1 bits so no corner of the grid can wrap.
    function automatic logic f_cov(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                   input logic [W-1:0] bx, input logic [W-1:0] by);
        logic [W-1:0]   dx, dy;
        logic [2*W:0]   ex, ey, s;
        dx = (ax >= bx) ? ax - bx : bx - ax;
        dy = (ay >= by) ? ay - by : by - ay;
        ex = {{(W+1){1'b0}}, dx};
        ey = {{(W+1){1'b0}}, dy};
        s  = ex * ex + ey * ey;
        f_cov = ({{(31-2*W){1'b0}}, s} <= R2_U);
    endfunction

    logic [W-1:0]  w_px, w_py, w_ox, w_oy;
    logic          w_hit, w_upd, w_last_cand, w_accept, w_improved;
    logic [CW-1:0] w_new_best;
    logic [TW-1:0] w_iter_nx;

    // Handshake: a beat transfers on the rising edge where IN_VALID and IN_READY are
    // both high; IN_VALID while IN_READY is low is ignored entirely.
    assign w_accept    = IN_VALID & r_ready;
    assign w_px        = r_px[r_idx];
    assign w_py        = r_py[r_idx];
    assign w_ox        = (r_state == S_SWEEP1) ? r_c2x : r_c1x;
    assign w_oy        = (r_state == S_SWEEP1) ? r_c2y : r_c1y;
    assign w_hit       = f_cov(r_cx, r_cy, w_px, w_py) | f_cov(w_ox, w_oy, w_px, w_py);
    assign w_upd       = r_count > r_best;
    assign w_new_best  = w_upd ? r_count : r_best;
    assign w_last_cand = (r_cx == MAXC) && (r_cy == MAXC);
    assign w_iter_nx   = r_iter + 1'b1;
    assign w_improved  = w_new_best > r_best_iter;

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_px[r_idx] <= X;
            r_py[r_idx] <= Y;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cmp       <= 1'b0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_c1x       <= CTR;
            r_c1y       <= CTR;
            r_c2x       <= CTR;
            r_c2y       <= CTR;
            r_count     <= '0;
            r_best      <= '0;
            r_best_iter <= '0;
            r_cover     <= '0;
            r_iter      <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        if (r_state == S_IDLE) begin
                            r_c1x   <= CTR;
                            r_c1y   <= CTR;
                            r_c2x   <= CTR;
                            r_c2y   <= CTR;
                            r_best  <= '0;
                            r_cover <= '0;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state     <= S_SWEEP1;
                            r_ready     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_idx       <= '0;
                            r_iter      <= '0;
                            r_cmp       <= 1'b0;
                            r_cx        <= '0;
                            r_cy        <= '0;
                            r_count     <= '0;
                            r_best_iter <= '0;
                        end else begin
                            r_state <= S_LOAD;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                S_SWEEP1, S_SWEEP2: begin
                    if (!r_cmp) begin
                        r_count <= r_count + CW'(w_hit);
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            r_cmp <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cmp   <= 1'b0;
                        r_count <= '0;
                        // Strict compare: ties keep the earlier raster candidate.
                        if (w_upd) begin
                            r_best <= r_count;
                            if (r_state == S_SWEEP1) begin
                                r_c1x <= r_cx;
                                r_c1y <= r_cy;
                            end else begin
                                r_c2x <= r_cx;
                                r_c2y <= r_cy;
                            end
                        end
                        if (r_cx == MAXC) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 1'b1;
                        end else begin
                            r_cx <= r_cx + 1'b1;
                        end
                        if (w_last_cand) begin
                            if (r_state == S_SWEEP1) begin
                                r_state <= S_SWEEP2;
                            end else begin
                                r_iter <= w_iter_nx;
                                if (!w_improved || (w_iter_nx == ITER_LIM)) begin
                                    r_state <= S_FIN;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_cover <= w_new_best;
                                end else begin
                                    r_state     <= S_SWEEP1;
                                    r_best_iter <= w_new_best;
                                end
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = r_ready;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign COVER     = r_cover;
    assign C1X       = r_c1x;
    assign C1Y       = r_c1y;
    assign C2X       = r_c2x;
    assign C2Y       = r_c2y;
    assign DBG_STATE = r_state;

endmodule
